// File: rtl/text_term_writer.sv
// Turns a byte stream (ASCII + CR/LF/BS/FF) into character-RAM write cycles for the 40x32 EL text display.
// Optional macro TERM_HW_SCROLL_EN: bottom-row newline scrolls via out_scroll_row instead of wrapping to row 0.
module text_term_writer #(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic                  in_main_clock,
  input  logic                  in_reset_n,
  input  logic [7:0]            in_char_data,
  input  logic                  in_char_valid,
  output logic                  out_char_ready,
  output logic [ADDR_WIDTH-1:0] out_ram_wr_address,
  output logic [7:0]            out_ram_wr_data,
  output logic                  out_ram_wr_en,
  output logic [5:0]            out_cursor_x,
  output logic [4:0]            out_cursor_y,
  output logic [4:0]            out_scroll_row,
  output logic                  out_busy
);

  localparam int unsigned CNT_W        = ADDR_WIDTH + 1;
  localparam int unsigned SCREEN_CELLS = COLS * ROWS;

  typedef enum logic [2:0] {
    INIT_CLEAR   = 3'd0,
    IDLE         = 3'd1,
    WRITE        = 3'd2,
    LINE_CLEAR   = 3'd3,
    SCREEN_CLEAR = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cx_q, cx_d;
  logic [4:0]            cy_q, cy_d;
  logic [4:0]            scroll_q, scroll_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic [5:0]            row_sum;
  logic [4:0]            phys_row;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [4:0]            nl_y, nl_scroll, nl_row;
  logic                  nl_clr;
  logic [ADDR_WIDTH-1:0] nl_base;
  logic                  printable;

  assign accept    = in_char_valid && ready_q;
  assign printable = (in_char_data >= 8'h20) && (in_char_data != 8'h7F);

  // Cursor position to RAM address through the scroll offset.
  always_comb begin
    row_sum  = {1'b0, cy_q} + {1'b0, scroll_q};
    phys_row = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : 5'(row_sum);
    cur_addr = ADDR_WIDTH'(phys_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(cx_q);
  end

  // Newline outcome: next row, scroll offset and which physical row (if any) must be blanked.
  always_comb begin
    nl_y      = cy_q;
    nl_scroll = scroll_q;
    nl_row    = '0;
    nl_clr    = 1'b0;
    if (cy_q < 5'(ROWS - 1)) begin
      nl_y = cy_q + 5'd1;
    end else begin
      nl_clr = 1'b1;
`ifdef TERM_HW_SCROLL_EN
      nl_scroll = (scroll_q == 5'(ROWS - 1)) ? 5'd0 : scroll_q + 5'd1;
      nl_row    = (nl_scroll == 5'd0) ? 5'(ROWS - 1) : nl_scroll - 5'd1;
`else
      nl_y   = '0;
      nl_row = '0;
`endif
    end
    nl_base = ADDR_WIDTH'(nl_row) * ADDR_WIDTH'(COLS);
  end

  // Next-state and next-output logic; every output is the registered copy of a *_d value.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    scroll_d = scroll_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    pend_d   = pend_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      INIT_CLEAR, SCREEN_CLEAR: begin
        if (cnt_q < CNT_W'(SCREEN_CELLS)) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(cnt_q);
          data_d  = CLEAR_CHAR;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d  = IDLE;
          cx_d     = '0;
          cy_d     = '0;
          scroll_d = '0;
        end
      end
      LINE_CLEAR: begin
        if (cnt_q < CNT_W'(COLS)) begin
          wr_en_d = 1'b1;
          addr_d  = base_q + ADDR_WIDTH'(cnt_q);
          data_d  = CLEAR_CHAR;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        // A glyph in the last cell of the bottom row still owes a line clear.
        if (pend_q) begin
          state_d = LINE_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          if (printable) begin
            state_d = WRITE;
            wr_en_d = 1'b1;
            addr_d  = cur_addr;
            data_d  = in_char_data;
            if (cx_q == 6'(COLS - 1)) begin
              cx_d     = '0;
              cy_d     = nl_y;
              scroll_d = nl_scroll;
              pend_d   = nl_clr;
              base_d   = nl_base;
            end else begin
              cx_d = cx_q + 6'd1;
            end
          end else begin
            case (in_char_data)
              8'h0D: cx_d = '0;
              8'h0A: begin
                cx_d     = '0;
                cy_d     = nl_y;
                scroll_d = nl_scroll;
                if (nl_clr) begin
                  state_d = LINE_CLEAR;
                  cnt_d   = '0;
                  base_d  = nl_base;
                end
              end
              8'h08: begin
                if (cx_q != 6'd0) begin
                  state_d = WRITE;
                  cx_d    = cx_q - 6'd1;
                  pend_d  = 1'b0;
                  wr_en_d = 1'b1;
                  addr_d  = cur_addr - ADDR_WIDTH'(1);
                  data_d  = CLEAR_CHAR;
                end
              end
              8'h0C: begin
                state_d = SCREEN_CLEAR;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = INIT_CLEAR;
    endcase

    // Ready drops for one cycle after every accepted byte so a held valid is never taken twice.
    ready_d = (state_d == IDLE) && !accept;
    busy_d  = (state_d == INIT_CLEAR) || (state_d == LINE_CLEAR) || (state_d == SCREEN_CLEAR);
  end

  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= INIT_CLEAR;
      cx_q     <= '0;
      cy_q     <= '0;
      scroll_q <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      scroll_q <= scroll_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign out_char_ready     = ready_q;
  assign out_ram_wr_en      = wr_en_q;
  assign out_ram_wr_address = addr_q;
  assign out_ram_wr_data    = data_q;
  assign out_cursor_x       = cx_q;
  assign out_cursor_y       = cy_q;
  assign out_scroll_row     = scroll_q;
  assign out_busy           = busy_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Scoreboard bench for text_term_writer: directed byte sequences, expected RAM writes queued and checked by a monitor.
module tb_text_term_writer;

  localparam int unsigned AW = 11;

`ifdef TERM_HW_SCROLL_EN
  localparam int LF_Y     = 31;
  localparam int LF_S     = 1;
  localparam int BR_LFS   = 0;
  localparam int BR_BASE  = 0;
  localparam int BR_CLR   = 40;
  localparam int BR_Y     = 31;
  localparam int BR_S     = 2;
`else
  localparam int LF_Y     = 0;
  localparam int LF_S     = 0;
  localparam int BR_LFS   = 31;
  localparam int BR_BASE  = 1240;
  localparam int BR_CLR   = 0;
  localparam int BR_Y     = 0;
  localparam int BR_S     = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          vin = 1'b0;
  logic          ready;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          wr_en;
  logic [5:0]    cx;
  logic [4:0]    cy;
  logic [4:0]    scroll;
  logic          busy;

  text_term_writer dut (
    .in_main_clock     (clk),
    .in_reset_n        (rst_n),
    .in_char_data      (din),
    .in_char_valid     (vin),
    .out_char_ready    (ready),
    .out_ram_wr_address(addr),
    .out_ram_wr_data   (data),
    .out_ram_wr_en     (wr_en),
    .out_cursor_x      (cx),
    .out_cursor_y      (cy),
    .out_scroll_row    (scroll),
    .out_busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;
  int  wr_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data 0x%02h, nothing expected", addr, data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", int'(addr), int'(mon_e.addr));
        check("wr_data", int'(data), int'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic push_wr(input int a, input int d);
    exp_q.push_back({AW'(a), 8'(d)});
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) push_wr(base + i, 8'h20);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("ready_timeout", int'(ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    din = b;
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic ready_low(output int n);
    n = 0;
    while (!ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic busy_run(output int n);
    int g = 0;
    n = 0;
    do begin
      @(negedge clk);
      g++;
      if (busy) n++;
    end while (!ready && g < 5000);
  endtask

  task automatic drain_check(input string name);
    @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic expect_cursor(input int x, input int y, input int s);
    check("cursor_x", int'(cx), x);
    check("cursor_y", int'(cy), y);
    check("scroll_row", int'(scroll), s);
  endtask

  task automatic check_reset_vals();
    check("rst_ready", int'(ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 1);
    expect_cursor(0, 0, 0);
  endtask

  initial begin
    int n;
    int target;
    int g;

    // Reset values and power-on clear.
    repeat (3) @(negedge clk);
    check_reset_vals();
    push_clear(0, 1280);
    rst_n = 1'b1;
    busy_run(n);
    check("init_busy_cycles", n, 1280);
    check("init_ready", int'(ready), 1);
    drain_check("init_queue_empty");
    expect_cursor(0, 0, 0);

    // 'A','B' land at addresses 0 and 1, ready drops one cycle each.
    push_wr(0, 8'h41);
    push_wr(1, 8'h42);
    send(8'h41);
    ready_low(n);
    check("ready_low_A", n, 1);
    send(8'h42);
    ready_low(n);
    check("ready_low_B", n, 1);
    drain_check("ab_queue_empty");
    expect_cursor(2, 0, 0);

    // Fill to column 39, then auto-wrap to row 1 without a line clear.
    for (int i = 2; i < 39; i++) begin
      push_wr(i, 8'h2E);
      send(8'h2E);
    end
    push_wr(39, 8'h43);
    send(8'h43);
    wait_ready();
    drain_check("wrap_queue_empty");
    expect_cursor(0, 1, 0);

    // Walk to the bottom row, then newline there clears physical row 0.
    for (int i = 0; i < 30; i++) send(8'h0A);
    wait_ready();
    drain_check("lf_walk_no_writes");
    expect_cursor(0, 31, 0);
    push_clear(0, 40);
    send(8'h0A);
    wait_ready();
    drain_check("lf_clear_queue_empty");
    expect_cursor(0, LF_Y, LF_S);

    // Backspace, carriage return, and backspace at column 0.
    for (int i = 0; i < 5; i++) begin
      push_wr(i, 8'h78);
      send(8'h78);
    end
    wait_ready();
    expect_cursor(5, LF_Y, LF_S);
    push_wr(4, 8'h20);
    send(8'h08);
    ready_low(n);
    check("ready_low_bs", n, 1);
    drain_check("bs_queue_empty");
    expect_cursor(4, LF_Y, LF_S);
    send(8'h0D);
    ready_low(n);
    check("ready_low_cr", n, 1);
    drain_check("cr_no_write");
    expect_cursor(0, LF_Y, LF_S);
    send(8'h08);
    wait_ready();
    drain_check("bs_x0_no_write");
    expect_cursor(0, LF_Y, LF_S);
    send(8'h01);
    wait_ready();
    drain_check("unknown_code_no_write");
    expect_cursor(0, LF_Y, LF_S);

    // Printable in the bottom-right cell: write first, then the line clear.
    for (int i = 0; i < BR_LFS; i++) send(8'h0A);
    for (int i = 0; i < 39; i++) push_wr(BR_BASE + i, 8'h23);
    push_wr(BR_BASE + 39, 8'h5A);
    push_clear(BR_CLR, 40);
    for (int i = 0; i < 39; i++) send(8'h23);
    send(8'h5A);
    wait_ready();
    drain_check("br_queue_empty");
    expect_cursor(0, BR_Y, BR_S);

    // Form feed, aborted by reset after 600 clear writes, then a full restart.
    push_clear(0, 600);
    target = wr_seen + 600;
    send(8'h0C);
    g = 0;
    while (wr_seen < target && g < 5000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("ff_reached_600", int'(wr_seen >= target), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    check("abort_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    push_clear(0, 1280);
    rst_n = 1'b1;
    busy_run(n);
    check("restart_busy_cycles", n, 1280);
    check("restart_ready", int'(ready), 1);
    drain_check("restart_queue_empty");
    expect_cursor(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_term_writer.md
Name: text_term_writer

Overview:
- Upstream stage of the EL display character path: turns a byte stream (ASCII plus control codes) into write cycles on the 40x32 character RAM write port (WrAddress/Data/WE).
- Tracks a text cursor and handles CR, LF, backspace and form-feed.
- Auto-wraps at end of line.
- Clears the character RAM after reset.
- Clears a line on wrap or scroll.

Parameters:
COLS, 40, characters per row
ROWS, 32, rows per screen
ADDR_WIDTH, 11, character RAM address width (COLS*ROWS <= 2**ADDR_WIDTH)
CLEAR_CHAR, 8'h20, glyph code written when clearing

Ports:
in_main_clock  input  1  system clock, same clock as character RAM WrClock
in_reset_n  input  1  asynchronous active-low reset
in_char_data  input  8  byte to print or control code
in_char_valid  input  1  in_char_data valid
out_char_ready  output  1  byte accepted on a cycle where valid&ready
out_ram_wr_address  output  ADDR_WIDTH  character RAM write address
out_ram_wr_data  output  8  character RAM write data
out_ram_wr_en  output  1  character RAM write enable, one write per cycle
out_cursor_x  output  6  current cursor column, 0..COLS-1
out_cursor_y  output  5  current cursor logical row, 0..ROWS-1
out_scroll_row  output  5  physical RAM row shown at display top, 0..ROWS-1
out_busy  output  1  high while any clear sequence runs

Behaviour:
- All outputs are registered.
- Reset values: out_char_ready=0, out_ram_wr_en=0, address=0, data=0, cursor_x=0, cursor_y=0, scroll_row=0, out_busy=1. The state is INIT_CLEAR.
- Reset asserted mid-operation aborts everything immediately. After release, a full clear restarts from address 0.
- States: INIT_CLEAR, IDLE, WRITE, LINE_CLEAR, SCREEN_CLEAR.
- INIT_CLEAR / SCREEN_CLEAR:
  - Write CLEAR_CHAR to addresses 0..COLS*ROWS-1, one per cycle, ascending (1280 cycles at default).
  - Then go to IDLE with cursor 0,0 and scroll_row=0.
  - out_busy=1 throughout.
- IDLE: out_char_ready=1. Acceptance happens on valid&ready only; the source holds data/valid until accepted. In every other state out_char_ready=0.
- Physical row = (cursor_y + scroll_row) mod ROWS.
- Address = physical_row*COLS + cursor_x, computed with ADDR_WIDTH-bit arithmetic.
- Accepted byte decode:
  - 0x20..0x7E and 0x80..0xFF: go to WRITE.
    - Next cycle: wr_en=1, data=byte, address = cursor position before advance.
    - Cursor then advances: x+1. At x==COLS-1, x=0 and a newline is performed.
  - 0x0D (CR): x=0, no write. Back to IDLE; ready returns next cycle.
  - 0x0A (LF): newline, with x=0.
  - 0x08 (BS): if x>0, x=x-1 and write CLEAR_CHAR at the new x via WRITE. At x==0: no change, no write.
  - 0x0C (FF): go to SCREEN_CLEAR.
  - Any other code: consumed, no effect.
- Newline:
  - If y<ROWS-1: y=y+1, no clear.
  - If y==ROWS-1: wrap/scroll (see Optional Feature) then LINE_CLEAR of the destination physical row. That is COLS writes of CLEAR_CHAR at ascending addresses, out_busy=1.
- Latency: printable byte accepted at cycle N → RAM write at N+1 → ready high again at N+2. Sustained throughput is one byte per 2 cycles.
- A printable char at x==COLS-1, y==ROWS-1 performs its write first, then LINE_CLEAR, then IDLE.
- out_ram_wr_en is never high in IDLE. Address and data hold their last value when wr_en=0.

Optional Feature:
Macro TERM_HW_SCROLL_EN.
- Defined: a newline at y==ROWS-1 keeps y=ROWS-1 and sets scroll_row=(scroll_row+1) mod ROWS. The cleared row is the new bottom physical row, (ROWS-1+scroll_row_new) mod ROWS. Downstream display adds scroll_row to its character row index.
- Undefined: y wraps to 0, physical row 0 is cleared, and out_scroll_row is tied to 0.

Test Plan:
- Release reset → out_busy=1 for exactly 1280 cycles, 1280 writes of 0x20 to addresses 0..1279, then ready=1, cursor 0,0.
- After init, send 'A','B' (0x41,0x42) → writes (addr 0,0x41), (addr 1,0x42), cursor_x=2; ready pulses low for 1 cycle per byte.
- From x=39,y=0, send 0x43 → write addr 39 data 0x43; cursor becomes 0,1; no LINE_CLEAR.
- At y=31, send 0x0A:
  - Without TERM_HW_SCROLL_EN: cursor 0,0, 40 writes of 0x20 to addr 0..39.
  - With TERM_HW_SCROLL_EN: cursor 0,31, scroll_row=1, 40 clear writes to addr 0..39 (physical row 0).
- Cursor x=5: send 0x08 → write 0x20 at x=4, cursor_x=4. At x=0, 0x08 → no write, cursor unchanged. 0x0D → x=0 with no write.
- Send 0x0C mid-screen, then assert in_reset_n=0 at clear cycle 600 → all outputs go to reset values immediately. After release, the clear restarts at address 0 and runs the full 1280 cycles.
